// File: rtl/bht_resolver_pkg.sv
// Shared types and constants for the BHT resolution unit.
package bht_resolver_pkg;

  localparam int unsigned IM_ADDR_BIT = 10;

  // Queue entry is {pc, hit, guess}; pc and guess are IM_ADDR_BIT wide.
  localparam int unsigned HIT_W = 1;

  typedef enum logic {
    RES_RUN   = 1'b0,
    RES_FLUSH = 1'b1
  } res_state_e;

  function automatic int unsigned entry_width(int unsigned addr_bits);
    return 2 * addr_bits + HIT_W;
  endfunction

endpackage

// File: rtl/bht_resolver_queue.sv
// In-order circular buffer of fetch predictions with push, pop and clear.
module res_queue #(
  parameter int unsigned WIDTH = 21,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (clear) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      // Power-of-two depth, so pointers wrap naturally.
      if (push) wr_d = wr_q + PW'(1);
      if (pop)  rd_d = rd_q + PW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_q] <= wdata;
  end

  assign full  = (cnt_q == CW'(DEPTH));
  assign count = cnt_q;
  assign head  = mem_q[rd_q];

endmodule

// File: rtl/bht_resolver.sv
// Retires fetch predictions in order, drives BHT updates and mispredict redirects.
// Optional BHT_RESOLVER_STATS_EN adds saturating branch/mispredict counters.
module bht_resolver #(
  parameter int unsigned IM_ADDR_BIT = bht_resolver_pkg::IM_ADDR_BIT,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   f_valid,
  input  logic [IM_ADDR_BIT-1:0] f_pc,
  input  logic                   f_hit,
  input  logic [IM_ADDR_BIT-1:0] f_guess,
  input  logic                   x_valid,
  input  logic                   x_is_branch,
  input  logic                   x_taken,
  input  logic [IM_ADDR_BIT-1:0] x_target,
  output logic                   full,
  output logic [CW-1:0]          count,
  output logic                   w_en,
  output logic                   succeed,
  output logic [IM_ADDR_BIT-1:0] pc_before_g,
  output logic [IM_ADDR_BIT-1:0] g_addr,
  output logic                   redirect,
  output logic [IM_ADDR_BIT-1:0] redirect_addr,
`ifdef BHT_RESOLVER_STATS_EN
  output logic [15:0]            stat_branches,
  output logic [15:0]            stat_mispredicts,
`endif
  output logic                   underflow
);

  import bht_resolver_pkg::*;

  localparam int unsigned EW = entry_width(IM_ADDR_BIT);

  res_state_e             state_q, state_d;
  logic [EW-1:0]          head;
  logic [IM_ADDR_BIT-1:0] head_pc, head_guess, actual;
  logic                   head_hit, run, pop, push, mispredict, update, underflow_d;

  logic                   w_en_q, succeed_q, redirect_q, underflow_q;
  logic [IM_ADDR_BIT-1:0] pc_before_g_q, g_addr_q, redirect_addr_q;

  res_queue #(
    .WIDTH(EW),
    .DEPTH(DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (mispredict),
    .wdata ({f_pc, f_hit, f_guess}),
    .full  (full),
    .count (count),
    .head  (head)
  );

  assign head_pc    = head[EW-1 -: IM_ADDR_BIT];
  assign head_hit   = head[IM_ADDR_BIT];
  assign head_guess = head[IM_ADDR_BIT-1:0];

  always_comb begin
    run         = (state_q == RES_RUN);
    pop         = en && run && x_valid && (count != '0);
    actual      = (x_is_branch && x_taken) ? x_target : head_pc + IM_ADDR_BIT'(4);
    mispredict  = pop && (actual != head_guess);
    // Non-branches that hit in the BHT are aliases; update them so they decay.
    update      = pop && (x_is_branch || head_hit);
    push        = en && run && f_valid && (!full || pop) && !mispredict;
    underflow_d = underflow_q || (en && run && x_valid && (count == '0));
    state_d     = state_q;
    if (en) begin
      unique case (state_q)
        RES_RUN:   if (mispredict) state_d = RES_FLUSH;
        RES_FLUSH: state_d = RES_RUN;
        default:   state_d = RES_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= RES_RUN;
      w_en_q          <= 1'b0;
      succeed_q       <= 1'b0;
      redirect_q      <= 1'b0;
      underflow_q     <= 1'b0;
      pc_before_g_q   <= '0;
      g_addr_q        <= '0;
      redirect_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      underflow_q <= underflow_d;
      w_en_q      <= update;
      redirect_q  <= mispredict;
      if (update) begin
        succeed_q     <= x_is_branch && x_taken;
        pc_before_g_q <= head_pc;
        g_addr_q      <= x_target;
      end
      if (mispredict) redirect_addr_q <= actual;
    end
  end

  assign w_en          = w_en_q;
  assign succeed       = succeed_q;
  assign pc_before_g   = pc_before_g_q;
  assign g_addr        = g_addr_q;
  assign redirect      = redirect_q;
  assign redirect_addr = redirect_addr_q;
  assign underflow     = underflow_q;

`ifdef BHT_RESOLVER_STATS_EN
  logic [15:0] br_q, mis_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      br_q  <= '0;
      mis_q <= '0;
    end else begin
      if (update && x_is_branch && (br_q != 16'hFFFF)) br_q <= br_q + 16'd1;
      if (mispredict && (mis_q != 16'hFFFF))           mis_q <= mis_q + 16'd1;
    end
  end

  assign stat_branches    = br_q;
  assign stat_mispredicts = mis_q;
`endif

endmodule

// File: tb/tb_bht_resolver.sv
// Directed bench: expected update/redirect pulses go to a scoreboard checked by a monitor.
module tb_bht_resolver;

  localparam int unsigned AW = 10;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW = 3;

  logic          clk = 1'b0;
  logic          rst, en, f_valid, f_hit, x_valid, x_is_branch, x_taken;
  logic [AW-1:0] f_pc, f_guess, x_target;
  logic          full, w_en, succeed, redirect, underflow;
  logic [CW-1:0] count;
  logic [AW-1:0] pc_before_g, g_addr, redirect_addr;
`ifdef BHT_RESOLVER_STATS_EN
  logic [15:0]   stat_branches, stat_mispredicts;
`endif

  bht_resolver #(
    .IM_ADDR_BIT(AW),
    .DEPTH(DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .f_valid       (f_valid),
    .f_pc          (f_pc),
    .f_hit         (f_hit),
    .f_guess       (f_guess),
    .x_valid       (x_valid),
    .x_is_branch   (x_is_branch),
    .x_taken       (x_taken),
    .x_target      (x_target),
    .full          (full),
    .count         (count),
    .w_en          (w_en),
    .succeed       (succeed),
    .pc_before_g   (pc_before_g),
    .g_addr        (g_addr),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
`ifdef BHT_RESOLVER_STATS_EN
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts),
`endif
    .underflow     (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          w;
    logic          s;
    logic [AW-1:0] pc;
    logic [AW-1:0] g;
    logic          r;
    logic [AW-1:0] ra;
    int            due;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every registered pulse must match the scoreboard head due this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        tests++;
        if (w_en !== e.w || redirect !== e.r ||
            (e.w && (succeed !== e.s || pc_before_g !== e.pc || g_addr !== e.g)) ||
            (e.r && redirect_addr !== e.ra)) begin
          fails++;
          $display("FAIL pulse@%0d: got w_en=%b succeed=%b pc=%h g=%h redirect=%b raddr=%h, want w_en=%b succeed=%b pc=%h g=%h redirect=%b raddr=%h",
                   cyc, w_en, succeed, pc_before_g, g_addr, redirect, redirect_addr,
                   e.w, e.s, e.pc, e.g, e.r, e.ra);
        end
      end else if (w_en === 1'b1 || redirect === 1'b1) begin
        tests++;
        fails++;
        $display("FAIL spurious_pulse@%0d: got w_en=%b redirect=%b, want none", cyc, w_en, redirect);
      end
    end
  end

  task automatic expect_out(input logic w, input logic s, input logic [AW-1:0] pc,
                            input logic [AW-1:0] g, input logic r, input logic [AW-1:0] ra);
    exp_t e;
    e.w = w; e.s = s; e.pc = pc; e.g = g; e.r = r; e.ra = ra; e.due = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    f_valid = 1'b0;
    x_valid = 1'b0;
  endtask

  task automatic set_push(input logic [AW-1:0] pc, input logic hit, input logic [AW-1:0] g);
    f_valid = 1'b1; f_pc = pc; f_hit = hit; f_guess = g;
  endtask

  task automatic set_pop(input logic br, input logic tk, input logic [AW-1:0] tgt);
    x_valid = 1'b1; x_is_branch = br; x_taken = tk; x_target = tgt;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; f_valid = 1'b0; f_hit = 1'b0; f_pc = '0; f_guess = '0;
    x_valid = 1'b0; x_is_branch = 1'b0; x_taken = 1'b0; x_target = '0;
    step(); step();
    rst = 1'b0;
    check("reset_count", 32'(count), 0);
    check("reset_full", 32'(full), 0);
    check("reset_underflow", 32'(underflow), 0);
    check("reset_pc_before_g", 32'(pc_before_g), 0);
    check("reset_redirect_addr", 32'(redirect_addr), 0);

    // Correctly predicted not-taken branch.
    set_push(10'h010, 1'b0, 10'h014); step();
    check("push1_count", 32'(count), 1);
    set_pop(1'b1, 1'b0, 10'h050);
    expect_out(1'b1, 1'b0, 10'h010, 10'h050, 1'b0, '0);
    step();
    check("pop1_count", 32'(count), 0);

    // Mispredicted taken branch, with fetch pushes in T and T+1 dropped.
    set_push(10'h020, 1'b0, 10'h024); step();
    set_pop(1'b1, 1'b1, 10'h080);
    set_push(10'h099, 1'b0, 10'h09D);
    expect_out(1'b1, 1'b1, 10'h020, 10'h080, 1'b1, 10'h080);
    step();
    check("mispred_count_t1", 32'(count), 0);
    set_push(10'h0A0, 1'b0, 10'h0A4); step();
    check("flush_push_dropped", 32'(count), 0);
    set_push(10'h0B0, 1'b0, 10'h0B4); step();
    check("push_t2_accepted", 32'(count), 1);
    set_pop(1'b0, 1'b0, 10'h000); step();   // non-branch, no hit, correct: no pulse
    check("nonbranch_pop_count", 32'(count), 0);

    // Fill, overflow drop, push+pop while full, then order check.
    for (int i = 0; i < 4; i++) begin
      set_push(AW'(10'h100 + 4 * i), 1'b0, AW'(10'h104 + 4 * i)); step();
    end
    check("fill_count", 32'(count), 4);
    check("fill_full", 32'(full), 1);
    set_push(10'h110, 1'b0, 10'h114); step();
    check("overflow_dropped", 32'(count), 4);
    set_push(10'h110, 1'b0, 10'h114);
    set_pop(1'b0, 1'b0, 10'h000); step();
    check("full_pushpop_count", 32'(count), 4);
    check("full_pushpop_full", 32'(full), 1);
    for (int i = 0; i < 4; i++) begin
      set_pop(1'b1, 1'b0, 10'h3AA);
      expect_out(1'b1, 1'b0, AW'(10'h104 + 4 * i), 10'h3AA, 1'b0, '0);
      step();
    end
    check("drain_count", 32'(count), 0);

    // Aliased non-branch with BHT hit: decay update plus redirect to pc+4.
    set_push(10'h030, 1'b1, 10'h040); step();
    set_pop(1'b0, 1'b1, 10'h077);
    expect_out(1'b1, 1'b0, 10'h030, 10'h077, 1'b1, 10'h034);
    step();
    step();
    // pc+4 wraps to 0 and matches the guess.
    set_push(10'h3FC, 1'b1, 10'h000); step();
    set_pop(1'b0, 1'b0, 10'h011);
    expect_out(1'b1, 1'b0, 10'h3FC, 10'h011, 1'b0, '0);
    step();

    // Underflow is sticky; en=0 freezes state and suppresses pulses.
    set_pop(1'b1, 1'b1, 10'h123); step();
    check("underflow_set", 32'(underflow), 1);
    step();
    check("underflow_sticky", 32'(underflow), 1);
    set_push(10'h200, 1'b0, 10'h204); step();
    en = 1'b0;
    set_pop(1'b1, 1'b1, 10'h300); step();
    check("en0_count_held", 32'(count), 1);
    en = 1'b1;
    rst = 1'b1; step();
    rst = 1'b0;
    check("rst_underflow", 32'(underflow), 0);
    check("rst_count", 32'(count), 0);
    check("rst_pc_before_g", 32'(pc_before_g), 0);

    // Three branches, last one mispredicted.
    set_push(10'h300, 1'b0, 10'h304); step();
    set_pop(1'b1, 1'b0, 10'h3F0);
    expect_out(1'b1, 1'b0, 10'h300, 10'h3F0, 1'b0, '0); step();
    set_push(10'h310, 1'b0, 10'h314); step();
    set_pop(1'b1, 1'b0, 10'h3F0);
    expect_out(1'b1, 1'b0, 10'h310, 10'h3F0, 1'b0, '0); step();
    set_push(10'h320, 1'b0, 10'h324); step();
    set_pop(1'b1, 1'b1, 10'h100);
    expect_out(1'b1, 1'b1, 10'h320, 10'h100, 1'b1, 10'h100); step();
`ifdef BHT_RESOLVER_STATS_EN
    check("stat_branches", 32'(stat_branches), 3);
    check("stat_mispredicts", 32'(stat_mispredicts), 1);
`endif
    step(); step();
    check("scoreboard_drained", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
